// File: rtl/fullchip_pkg.sv
// Shared definitions for the attention instruction sequencer and its host:
// state encoding, instruction-word bit map and the field packer.
package fullchip_pkg;

    localparam int ADDR_W = 4;
    localparam int INST_W = 2 * ADDR_W + 9;
    localparam int CNT_W  = 8;

    // Instruction word bit positions, LSB upward.
    localparam int BIT_PMEM_WR        = 0;
    localparam int BIT_PMEM_RD        = 1;
    localparam int BIT_KMEM_WR        = 2;
    localparam int BIT_KMEM_RD        = 3;
    localparam int BIT_QMEM_WR        = 4;
    localparam int BIT_QMEM_RD        = 5;
    localparam int BIT_LOAD           = 6;
    localparam int BIT_EXECUTE        = 7;
    localparam int BIT_PMEM_ADD_LSB   = 8;
    localparam int BIT_QKMEM_ADD_LSB  = 8 + ADDR_W;
    localparam int BIT_OFIFO_RD       = 8 + 2 * ADDR_W;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_KLOAD  = 4'd1,
        ST_KTAIL  = 4'd2,
        ST_WAIT_K = 4'd3,
        ST_EXEC   = 4'd4,
        ST_WAIT_X = 4'd5,
        ST_DRAIN  = 4'd6,
        ST_READ   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    typedef struct packed {
        logic              ofifo_rd;
        logic [ADDR_W-1:0] qkmem_add;
        logic [ADDR_W-1:0] pmem_add;
        logic              execute;
        logic              load;
        logic              qmem_rd;
        logic              qmem_wr;
        logic              kmem_rd;
        logic              kmem_wr;
        logic              pmem_rd;
        logic              pmem_wr;
    } inst_fields_t;

    // Place each field at its fixed bit position in the instruction word.
    function automatic logic [INST_W-1:0] pack_inst(input inst_fields_t f);
        logic [INST_W-1:0] w;
        w                                  = '0;
        w[BIT_PMEM_WR]                     = f.pmem_wr;
        w[BIT_PMEM_RD]                     = f.pmem_rd;
        w[BIT_KMEM_WR]                     = f.kmem_wr;
        w[BIT_KMEM_RD]                     = f.kmem_rd;
        w[BIT_QMEM_WR]                     = f.qmem_wr;
        w[BIT_QMEM_RD]                     = f.qmem_rd;
        w[BIT_LOAD]                        = f.load;
        w[BIT_EXECUTE]                     = f.execute;
        w[BIT_PMEM_ADD_LSB +: ADDR_W]      = f.pmem_add;
        w[BIT_QKMEM_ADD_LSB +: ADDR_W]     = f.qkmem_add;
        w[BIT_OFIFO_RD]                    = f.ofifo_rd;
        return w;
    endfunction

endpackage

// File: rtl/seq_cnt.sv
// Loadable up-counter with a terminal-count flag against a run-time limit.
module seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    // Count register: load has priority over increment, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == last);

endmodule

// File: rtl/attn_inst_seq.sv
// Attention-pass instruction sequencer: K preload, Q execute, flow-controlled
// ofifo drain into pmem and optional pmem readback, from a single start pulse.
module attn_inst_seq
    import fullchip_pkg::*;
#(
    parameter int COL   = 8,
    parameter int MAX_Q = 8,
    parameter int GAP   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   n_q,
    input  logic              skip_kload,
    input  logic              readback,
    input  logic              abort,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        phase
);

    state_t            state_r, next_state_s;
    logic [ADDR_W:0]   n_q_r;
    logic              readback_r;
    logic              latch_s, err_s;
    logic [CNT_W-1:0]  c_r, c_nxt_s, c_last_s;
    logic              c_tc_s, c_load_s, c_en_s;
    logic [ADDR_W-1:0] beat_r;
    logic              beat_tc_s, beat_load_s, accept_s;
    inst_fields_t      fields_s;
    logic [INST_W-1:0] inst_r;
    logic              busy_r, done_r, err_r;
    logic [3:0]        phase_r;

    // Next-state selection, per-state run length, start acceptance and abort.
    always_comb begin
        next_state_s = state_r;
        err_s        = 1'b0;
        latch_s      = 1'b0;
        c_last_s     = '0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    if ((n_q == '0) || (n_q > (ADDR_W+1)'(MAX_Q))) begin
                        err_s = 1'b1;
                    end else begin
                        latch_s      = 1'b1;
                        next_state_s = skip_kload ? ST_EXEC : ST_KLOAD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_KLOAD: begin
                c_last_s     = CNT_W'(COL + 1);
                next_state_s = c_tc_s ? ST_KTAIL : ST_KLOAD;
            end
            ST_KTAIL:  next_state_s = ST_WAIT_K;
            ST_WAIT_K: begin
                c_last_s     = CNT_W'(GAP - 1);
                next_state_s = c_tc_s ? ST_EXEC : ST_WAIT_K;
            end
            ST_EXEC: begin
                c_last_s     = CNT_W'(n_q_r);
                next_state_s = c_tc_s ? ST_WAIT_X : ST_EXEC;
            end
            ST_WAIT_X: begin
                c_last_s     = CNT_W'(GAP - 1);
                next_state_s = c_tc_s ? ST_DRAIN : ST_WAIT_X;
            end
            ST_DRAIN: begin
                if (beat_tc_s) begin
                    next_state_s = readback_r ? ST_READ : ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_READ: begin
                c_last_s     = CNT_W'(n_q_r);
                next_state_s = c_tc_s ? ST_DONE : ST_READ;
            end
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
        if (abort) begin
            next_state_s = ST_IDLE;
            err_s        = 1'b0;
            latch_s      = 1'b0;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Counter control and the counter value the next cycle will carry.
    always_comb begin
        c_load_s    = (next_state_s != state_r);
        c_en_s      = (state_r != ST_IDLE);
        beat_load_s = (next_state_s != ST_DRAIN);
        accept_s    = (next_state_s == ST_DRAIN) && ofifo_valid;
        if (c_load_s) begin
            c_nxt_s = '0;
        end else if (c_en_s) begin
            c_nxt_s = c_r + 8'd1;
        end else begin
            c_nxt_s = c_r;
        end
    end

    seq_cnt #(.W(CNT_W)) u_state_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (c_load_s),
        .en       (c_en_s),
        .load_val ({CNT_W{1'b0}}),
        .last     (c_last_s),
        .cnt      (c_r),
        .tc       (c_tc_s)
    );

    seq_cnt #(.W(ADDR_W)) u_beat_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (beat_load_s),
        .en       (accept_s),
        .load_val ({ADDR_W{1'b0}}),
        .last     (n_q_r[ADDR_W-1:0]),
        .cnt      (beat_r),
        .tc       (beat_tc_s)
    );

    // Instruction fields for the cycle being entered; unused fields stay 0.
    always_comb begin
        fields_s = '0;
        case (next_state_s)
            ST_KLOAD: begin
                fields_s.load    = 1'b1;
                fields_s.kmem_rd = (c_nxt_s >= 8'd1);
                if (c_nxt_s >= 8'd2) begin
                    fields_s.qkmem_add = ADDR_W'(c_nxt_s - 8'd1);
                end else begin
                    fields_s.qkmem_add = '0;
                end
            end
            ST_KTAIL: fields_s.load = 1'b1;
            ST_EXEC: begin
                fields_s.execute   = 1'b1;
                fields_s.qmem_rd   = 1'b1;
                fields_s.qkmem_add = c_nxt_s[ADDR_W-1:0];
            end
            ST_DRAIN: begin
                fields_s.ofifo_rd = accept_s;
                fields_s.pmem_wr  = accept_s;
                fields_s.pmem_add = accept_s ? beat_r : '0;
            end
            ST_READ: begin
                fields_s.pmem_rd  = 1'b1;
                fields_s.pmem_add = c_nxt_s[ADDR_W-1:0];
            end
            default: fields_s = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Pass configuration captured when a start is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q_r      <= '0;
            readback_r <= 1'b0;
        end else if (latch_s) begin
            n_q_r      <= n_q;
            readback_r <= readback;
        end else begin
            n_q_r      <= n_q_r;
            readback_r <= readback_r;
        end
    end

    // Output registers, aligned with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            phase_r <= 4'd0;
        end else begin
            inst_r  <= pack_inst(fields_s);
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
            err_r   <= err_s;
            phase_r <= next_state_s;
        end
    end

    assign inst  = inst_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;
    assign phase = phase_r;

endmodule
